// File: rtl/d_link_pkg.sv
// Shared D-line link definitions: frame FSM states, line levels and a width helper.
// The receiver end uses the same line-level constants.
package d_link_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } d_state_e;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Bits needed to hold counts 0..max_count-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count > 1) ? $clog2(max_count) : 1;
    endfunction

endpackage

// File: rtl/d_serial_baud_tick.sv
// Bit-period timer: registered tick high in the last cycle of every CLKS_PER_BIT window.
// clear restarts the window so the next tick lands CLKS_PER_BIT cycles later.
module d_serial_baud_tick
    import d_link_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = cnt_width(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             tick_nxt;

    // tick is registered from the next count so it always equals (cnt == LAST).
    always_comb begin
        cnt_nxt  = cnt;
        tick_nxt = 1'b0;
        if (clear || cnt == LAST) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt + CNT_W'(1);
        end
        tick_nxt = (cnt_nxt == LAST);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_nxt;
            tick <= tick_nxt;
        end
    end

endmodule

// File: rtl/d_serial_tx.sv
// D-line serial transmitter: accepts a word on valid/ready and drives a registered
// start / LSB-first data / stop frame, each bit held for CLKS_PER_BIT cycles.
module d_serial_tx
    import d_link_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned IDX_W = cnt_width(WIDTH);
    localparam logic [IDX_W-1:0] LAST_BIT = IDX_W'(WIDTH - 1);

    d_state_e         state;
    d_state_e         state_nxt;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] shift_nxt;
    logic [IDX_W-1:0] bit_idx;
    logic [IDX_W-1:0] bit_idx_nxt;
    logic             ser_nxt;
    logic             busy_nxt;
    logic             ready_nxt;
    logic             done_nxt;

    logic             tick;
    logic             baud_clear_c;
    logic             accept_c;
    logic [WIDTH-1:0] shifted_c;

    assign accept_c     = valid_in & ready_out;
    assign baud_clear_c = (state == IDLE);
    assign shifted_c    = shift_reg >> 1;

    // Held in clear while idle, so the start bit's period begins on the accept edge.
    d_serial_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_tick (
        .clk   (clk),
        .rst   (rst),
        .clear (baud_clear_c),
        .tick  (tick)
    );

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_nxt   = state;
        shift_nxt   = shift_reg;
        bit_idx_nxt = bit_idx;
        ser_nxt     = ser_out;
        busy_nxt    = busy;
        ready_nxt   = ready_out;
        done_nxt    = 1'b0;

        unique case (state)
            IDLE: begin
                if (accept_c) begin
                    state_nxt   = START;
                    shift_nxt   = data_in;
                    bit_idx_nxt = '0;
                    ser_nxt     = START_BIT;
                    busy_nxt    = 1'b1;
                    ready_nxt   = 1'b0;
                end
            end
            START: begin
                if (tick) begin
                    state_nxt = DATA;
                    ser_nxt   = shift_reg[0];
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == LAST_BIT) begin
                        state_nxt = STOP;
                        ser_nxt   = STOP_BIT;
                    end else begin
                        bit_idx_nxt = bit_idx + IDX_W'(1);
                        shift_nxt   = shifted_c;
                        ser_nxt     = shifted_c[0];
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_nxt = IDLE;
                    ser_nxt   = LINE_IDLE;
                    busy_nxt  = 1'b0;
                    ready_nxt = 1'b1;
                    done_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                ser_nxt   = LINE_IDLE;
                busy_nxt  = 1'b0;
                ready_nxt = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_idx   <= '0;
            ser_out   <= LINE_IDLE;
            busy      <= 1'b0;
            ready_out <= 1'b1;
            done      <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            bit_idx   <= bit_idx_nxt;
            ser_out   <= ser_nxt;
            busy      <= busy_nxt;
            ready_out <= ready_nxt;
            done      <= done_nxt;
        end
    end

endmodule

// File: tb/tb_d_serial_tx.sv
// Self-checking bench for d_serial_tx: two instances (WIDTH=8/CLKS_PER_BIT=4 and
// WIDTH=4/CLKS_PER_BIT=1) checked cycle by cycle against a frame-level model.
module tb_d_serial_tx;

    localparam int W_A = 8;
    localparam int C_A = 4;
    localparam int W_B = 4;
    localparam int C_B = 1;
    localparam int FRAME_A = (W_A + 2) * C_A;
    localparam int FRAME_B = (W_B + 2) * C_B;
    localparam logic [3:0] IDLE_OBS = 4'b1010;  // ser=1 busy=0 ready=1 done=0

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_a;
    logic       valid_a;
    logic       ready_a, ser_a, busy_a, done_a;
    logic [3:0] data_b;
    logic       valid_b;
    logic       ready_b, ser_b, busy_b, done_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    d_serial_tx #(.WIDTH(W_A), .CLKS_PER_BIT(C_A)) dut_a (
        .clk(clk), .rst(rst), .data_in(data_a), .valid_in(valid_a),
        .ready_out(ready_a), .ser_out(ser_a), .busy(busy_a), .done(done_a)
    );

    d_serial_tx #(.WIDTH(W_B), .CLKS_PER_BIT(C_B)) dut_b (
        .clk(clk), .rst(rst), .data_in(data_b), .valid_in(valid_b),
        .ready_out(ready_b), .ser_out(ser_b), .busy(busy_b), .done(done_b)
    );

    // Line level in cycle k (1 = first cycle after accept) from the frame layout.
    function automatic logic exp_level(input logic [7:0] word, input int k, input int w, input int c);
        int idx;
        idx = (k - 1) / c;
        if (idx == 0) return 1'b0;
        if (idx <= w) return word[idx - 1];
        return 1'b1;
    endfunction

    // Expected {ser, busy, ready, done} for cycle k of a frame; cycle after the frame is the done cycle.
    function automatic logic [3:0] exp_obs(input logic [7:0] word, input int k, input int w, input int c);
        if (k <= (w + 2) * c) return {exp_level(word, k, w, c), 1'b1, 1'b0, 1'b0};
        return 4'b1011;
    endfunction

    task automatic test_reset();
        logic [3:0] obs;
        rst     = 1'b0;
        valid_a = 1'b1;
        data_a  = 8'($urandom);
        valid_b = 1'b1;
        data_b  = 4'($urandom);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            obs = {ser_a, busy_a, ready_a, done_a};
            n_checks++;
            if (obs !== IDLE_OBS) begin
                n_fail++;
                $display("FAIL reset_a cyc=%0d: got %b expected %b", i, obs, IDLE_OBS);
            end
            obs = {ser_b, busy_b, ready_b, done_b};
            n_checks++;
            if (obs !== IDLE_OBS) begin
                n_fail++;
                $display("FAIL reset_b cyc=%0d: got %b expected %b", i, obs, IDLE_OBS);
            end
        end
        valid_a = 1'b0;
        valid_b = 1'b0;
        rst     = 1'b1;
        @(negedge clk);
        obs = {ser_a, busy_a, ready_a, done_a};
        n_checks++;
        if (obs !== IDLE_OBS) begin
            n_fail++;
            $display("FAIL reset_release: got %b expected %b", obs, IDLE_OBS);
        end
    endtask

    task automatic test_single_frame(input logic [7:0] word);
        logic [3:0] obs;
        logic [3:0] exp;
        @(negedge clk);
        n_checks++;
        if (ready_a !== 1'b1) begin
            n_fail++;
            $display("FAIL frame_ready word=%h: got %b expected 1", word, ready_a);
        end
        data_a  = word;
        valid_a = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= FRAME_A + 1; k++) begin
            @(negedge clk);
            obs = {ser_a, busy_a, ready_a, done_a};
            exp = exp_obs(word, k, W_A, C_A);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL frame word=%h k=%0d: got %b expected %b", word, k, obs, exp);
            end
            if (k == 1) begin
                valid_a = 1'b0;
                data_a  = 8'($urandom);
            end
        end
        @(negedge clk);
        obs = {ser_a, busy_a, ready_a, done_a};
        n_checks++;
        if (obs !== IDLE_OBS) begin
            n_fail++;
            $display("FAIL frame_after word=%h: got %b expected %b", word, obs, IDLE_OBS);
        end
    endtask

    task automatic test_random_frames();
        for (int n = 0; n < 5; n++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            test_single_frame(8'($urandom));
        end
    endtask

    task automatic test_input_stability();
        logic [3:0] obs;
        logic [3:0] exp;
        @(negedge clk);
        data_a  = 8'h3C;
        valid_a = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= FRAME_A + 1; k++) begin
            @(negedge clk);
            obs = {ser_a, busy_a, ready_a, done_a};
            exp = exp_obs(8'h3C, k, W_A, C_A);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL stability k=%0d: got %b expected %b", k, obs, exp);
            end
            if (k == 1) data_a = 8'h00;
            if (k == FRAME_A + 1) valid_a = 1'b0;
        end
        @(negedge clk);
        obs = {ser_a, busy_a, ready_a, done_a};
        n_checks++;
        if (obs !== IDLE_OBS) begin
            n_fail++;
            $display("FAIL stability_single_accept: got %b expected %b", obs, IDLE_OBS);
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] obs;
        logic [3:0] exp;
        logic [7:0] word;
        int kk;
        int n_done;
        int first_done;
        int last_done;
        n_done     = 0;
        first_done = -1;
        last_done  = -1;
        @(negedge clk);
        data_a  = 8'h01;
        valid_a = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 2 * (FRAME_A + 1); k++) begin
            @(negedge clk);
            word = (k <= FRAME_A + 1) ? 8'h01 : 8'hFF;
            kk   = (k <= FRAME_A + 1) ? k : k - (FRAME_A + 1);
            obs  = {ser_a, busy_a, ready_a, done_a};
            exp  = exp_obs(word, kk, W_A, C_A);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL b2b k=%0d: got %b expected %b", k, obs, exp);
            end
            if (done_a === 1'b1) begin
                n_done++;
                if (first_done < 0) first_done = k;
                last_done = k;
            end
            if (k == 1) data_a = 8'hFF;
            if (k == 2 * (FRAME_A + 1)) valid_a = 1'b0;
        end
        n_checks++;
        if (n_done != 2 || last_done - first_done != FRAME_A + 1) begin
            n_fail++;
            $display("FAIL b2b_done_spacing: got %0d pulses %0d apart expected 2 pulses %0d apart",
                     n_done, last_done - first_done, FRAME_A + 1);
        end
    endtask

    task automatic test_mid_frame_reset();
        logic [3:0] obs;
        logic [3:0] exp;
        @(negedge clk);
        data_a  = 8'hC3;
        valid_a = 1'b1;
        @(posedge clk);
        // Third data bit occupies cycles 3*C_A+1 .. 4*C_A.
        for (int k = 1; k <= 3 * C_A + 2; k++) begin
            @(negedge clk);
            obs = {ser_a, busy_a, ready_a, done_a};
            exp = exp_obs(8'hC3, k, W_A, C_A);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL midrst_pre k=%0d: got %b expected %b", k, obs, exp);
            end
            if (k == 1) valid_a = 1'b0;
        end
        #1 rst = 1'b0;
        #1;
        obs = {ser_a, busy_a, ready_a, done_a};
        n_checks++;
        if (obs !== IDLE_OBS) begin
            n_fail++;
            $display("FAIL midrst_async: got %b expected %b", obs, IDLE_OBS);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            obs = {ser_a, busy_a, ready_a, done_a};
            n_checks++;
            if (obs !== IDLE_OBS) begin
                n_fail++;
                $display("FAIL midrst_hold cyc=%0d: got %b expected %b", i, obs, IDLE_OBS);
            end
        end
        rst = 1'b1;
        for (int i = 0; i < 2 * C_A; i++) begin
            @(negedge clk);
            n_checks++;
            if (done_a !== 1'b0) begin
                n_fail++;
                $display("FAIL midrst_no_done cyc=%0d: got %b expected 0", i, done_a);
            end
        end
        test_single_frame(8'h5A);
    endtask

    task automatic test_clks1(input logic [3:0] word);
        logic [3:0] obs;
        logic [3:0] exp;
        @(negedge clk);
        n_checks++;
        if (ready_b !== 1'b1) begin
            n_fail++;
            $display("FAIL clks1_ready word=%h: got %b expected 1", word, ready_b);
        end
        data_b  = word;
        valid_b = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= FRAME_B + 1; k++) begin
            @(negedge clk);
            obs = {ser_b, busy_b, ready_b, done_b};
            exp = exp_obs({4'b0000, word}, k, W_B, C_B);
            n_checks++;
            if (obs !== exp) begin
                n_fail++;
                $display("FAIL clks1 word=%h k=%0d: got %b expected %b", word, k, obs, exp);
            end
            if (k == 1) begin
                valid_b = 1'b0;
                data_b  = 4'($urandom);
            end
        end
    endtask

    initial begin
        data_a  = '0;
        valid_a = 1'b0;
        data_b  = '0;
        valid_b = 1'b0;
        test_reset();
        test_single_frame(8'hA5);
        test_input_stability();
        test_back_to_back();
        test_mid_frame_reset();
        test_random_frames();
        test_clks1(4'b1001);
        for (int n = 0; n < 4; n++) test_clks1(4'($urandom));
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
